mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access stage. Sits directly downstream of the EX/MEM pipeline register and upstream of the MEM/WB register.
- Consumes the ex_mem_reg_t bundle and drives a single-outstanding data-memory request/grant/response bus.
- Aligns store data and byte enables, and extracts and sign- or zero-extends load data.
- Raises a pipeline stall while an access is in flight.
- Produces the mem_wb_reg_t bundle and flags misaligned-access and bus-timeout faults.

Parameters:
- XLEN, 32, datapath width. Only 32 is supported.
- TIMEOUT_CYCLES, 256, maximum cycles spent in WAIT_RSP before a bus error is declared. Must be at least 2.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  synchronous, active-high.
- in  input  ex_mem_reg_t  stage input from the EX/MEM register; uses alu_result, rs2_data_str, rd_addr, ctrl, valid_ex_mem.
- dmem_req  output  1  request valid; held until dmem_gnt.
- dmem_we  output  1  1 = store.
- dmem_addr  output  32  word-aligned address, alu_result[31:2],2'b00.
- dmem_be  output  4  byte enables.
- dmem_wdata  output  32  lane-shifted store data.
- dmem_gnt  input  1  request accepted this cycle.
- dmem_rvalid  input  1  load response valid.
- dmem_rdata  input  32  load response word.
- mem_stall  output  1  holds the EX/MEM register and all upstream stages.
- out  output  mem_wb_reg_t  to the MEM/WB register; valid_mem_wb=0 whenever mem_stall=1.
- fault  output  1  one-cycle pulse: misaligned access or bus timeout.
- fault_cause  output  2  0=none, 1=misaligned load, 2=misaligned store, 3=bus timeout.

Behaviour:
- A memory op is `in.valid_ex_mem && (ctrl.mem_read || ctrl.mem_write)`. Non-memory ops pass through combinationally with zero latency, mem_stall=0, and mem_rdata=0.
- Misaligned cases: half with addr[0]=1, or word with addr[1:0]!=0.
  - No bus request is issued.
  - out.valid_mem_wb=1 with ctrl.reg_write forced to 0.
  - fault=1 with cause 1 or 2. No stall.
- FSM states: IDLE, WAIT_RSP, RSP_DONE. Reset forces IDLE, clears load_buf and the timeout counter.
- IDLE, aligned memory op: dmem_req=1.
  - Store with gnt: the op completes this cycle and mem_stall=0.
  - Store without gnt: mem_stall=1 and the state stays IDLE, with the request re-presented next cycle. The held input keeps the request stable.
  - Load with gnt: go to WAIT_RSP. mem_stall=1.
  - Load without gnt: mem_stall=1 and the state stays IDLE.
- WAIT_RSP:
  - dmem_req=0. Exactly one access is outstanding. mem_stall=1 and the counter increments.
  - On dmem_rvalid: capture dmem_rdata into load_buf and go to RSP_DONE.
  - When counter == TIMEOUT_CYCLES-1 without rvalid: go to RSP_DONE with a timeout flag. This produces fault=1, cause=3, and reg_write suppressed in RSP_DONE.
  - dmem_gnt in WAIT_RSP is ignored.
- RSP_DONE: mem_stall=0, out carries the extracted load_buf, and fault pulses if a timeout occurred. Unconditionally return to IDLE. One-cycle bubble-free release: the EX/MEM register advances on this edge.
- Load extraction by size and addr[1:0]:
  - Byte selects lane addr[1:0]; half selects lane addr[1].
  - Sign-extend unless ctrl.mem_unsigned is set.
  - Word passes through unchanged.
- Store alignment:
  - Byte: be=4'b0001<<addr[1:0]; wdata is the byte replicated ×4.
  - Half: be=4'b0011<<{addr[1],1'b0}; wdata is the half replicated ×2.
  - Word: be=4'b1111.
- dmem_rvalid outside WAIT_RSP is ignored.
- Reset mid-access: FSM returns to IDLE and the pending response is dropped. The memory is reset by the same signal.
- Outputs after reset: dmem_req=0, mem_stall=0, fault=0, and out has all fields 0 when in is invalid.

Decomposition:
- Add to riscv_pkg:
  - mem_wb_reg_t {alu_result, mem_rdata, rd_addr, ctrl, valid_mem_wb}.
  - Ctrl fields mem_read, mem_write, mem_size[1:0] (0=B, 1=H, 2=W), mem_unsigned, reg_write, wb_sel.
  - mem_fsm_e.
  - Fault-cause localparams.
- One combinational sub-module, lsu_align, handles store be/wdata generation and load extract/extend, so it can be unit-tested in isolation.

Test Plan:
- Word load, addr=0x100, gnt immediate, rvalid 3 cycles later with 0xDEADBEEF -> mem_stall high 4 cycles; RSP_DONE out.mem_rdata=0xDEADBEEF, valid_mem_wb=1.
- LB, addr=0x103, rdata=0x80FF_FFFF -> mem_rdata=0xFFFF_FF80. LBU at the same address -> 0x0000_0080.
- SH, addr=0x202, rs2=0x1234ABCD, gnt delayed 2 cycles -> dmem_req stays high 3 cycles with be=4'b1100 and wdata=0xABCDABCD; mem_stall drops on the gnt cycle.
- LW at addr=0x101 -> no dmem_req, fault=1 with cause=1, reg_write=0, mem_stall=0.
- Load granted, no rvalid, TIMEOUT_CYCLES=8 -> after 8 cycles in WAIT_RSP: RSP_DONE, fault=1 with cause=3, reg_write=0, stall released.
- Reset asserted in WAIT_RSP -> next cycle IDLE, mem_stall=0; a late rvalid is ignored.

Source files
------------

// File: rtl/mem_stage_pkg.sv
// Shared types for the memory-access stage: pipeline bundles, FSM states,
// access sizes and fault causes.
package mem_stage_pkg;

  typedef struct packed {
    logic       mem_read;
    logic       mem_write;
    logic [1:0] mem_size;
    logic       mem_unsigned;
    logic       reg_write;
    logic [1:0] wb_sel;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] rs2_data_str;
    logic [4:0]  rd_addr;
    ctrl_t       ctrl;
    logic        valid_ex_mem;
  } ex_mem_reg_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_rdata;
    logic [4:0]  rd_addr;
    ctrl_t       ctrl;
    logic        valid_mem_wb;
  } mem_wb_reg_t;

  typedef enum logic [1:0] {IDLE, WAIT_RSP, RSP_DONE} mem_fsm_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  localparam logic [1:0] FC_NONE        = 2'd0;
  localparam logic [1:0] FC_MISALIGN_LD = 2'd1;
  localparam logic [1:0] FC_MISALIGN_ST = 2'd2;
  localparam logic [1:0] FC_TIMEOUT     = 2'd3;

  // Sizes 2 and 3 are both treated as word accesses.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    return (size == SZ_H) ? addr_lo[0] :
           (size == SZ_B) ? 1'b0 : (addr_lo != 2'b00);
  endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Single-outstanding data-memory request/grant/response bus.
interface mem_stage_if;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt;
  logic        dmem_rvalid;
  logic [31:0] dmem_rdata;

  modport master (
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_gnt, dmem_rvalid, dmem_rdata
  );

  modport slave (
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_gnt, dmem_rvalid, dmem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu_align.sv
// Combinational lane logic: store byte-enable/data steering and load
// lane extraction with sign or zero extension.
module mem_stage_lsu_align
  import mem_stage_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  input  logic [31:0] st_data,
  input  logic [31:0] ld_word,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] ld_data
);

  function automatic logic [31:0] ext8(input logic signed [7:0] v, input logic uns);
    logic signed [31:0] s;
    s = v;
    return uns ? {24'h0, v} : s;
  endfunction

  function automatic logic [31:0] ext16(input logic signed [15:0] v, input logic uns);
    logic signed [31:0] s;
    s = v;
    return uns ? {16'h0, v} : s;
  endfunction

  always_comb begin
    be    = 4'b1111;
    wdata = st_data;
    case (size)
      SZ_B: begin
        be    = 4'b0001 << addr_lo;
        wdata = {4{st_data[7:0]}};
      end
      SZ_H: begin
        be    = 4'b0011 << {addr_lo[1], 1'b0};
        wdata = {2{st_data[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_data = ld_word;
    case (size)
      SZ_B:    ld_data = ext8(ld_word[{addr_lo, 3'b000} +: 8], is_unsigned);
      SZ_H:    ld_data = ext16(addr_lo[1] ? ld_word[31:16] : ld_word[15:0], is_unsigned);
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: issues one data-memory access at a time, stalls the
// pipeline while it is outstanding and reports misalignment / bus timeout.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  ex_mem_reg_t in,
  mem_stage_if.master dmem,
  output logic        mem_stall,
  output mem_wb_reg_t out,
  output logic        fault,
  output logic [1:0]  fault_cause
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mem_fsm_e       state, state_nxt;
  logic [CW-1:0]  cnt, cnt_nxt;
  logic [XLEN-1:0] load_buf, load_buf_nxt;
  logic           tmo, tmo_nxt;

  logic        is_mem, misaligned;
  logic [31:0] ld_data;

  assign is_mem     = in.valid_ex_mem && (in.ctrl.mem_read || in.ctrl.mem_write);
  assign misaligned = is_misaligned(in.ctrl.mem_size, in.alu_result[1:0]);

  assign dmem.dmem_we   = in.ctrl.mem_write;
  assign dmem.dmem_addr = {in.alu_result[31:2], 2'b00};

  mem_stage_lsu_align u_align (
    .addr_lo     (in.alu_result[1:0]),
    .size        (in.ctrl.mem_size),
    .is_unsigned (in.ctrl.mem_unsigned),
    .st_data     (in.rs2_data_str),
    .ld_word     (load_buf),
    .be          (dmem.dmem_be),
    .wdata       (dmem.dmem_wdata),
    .ld_data     (ld_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      load_buf <= '0;
      tmo      <= 1'b0;
    end else begin
      state    <= state_nxt;
      cnt      <= cnt_nxt;
      load_buf <= load_buf_nxt;
      tmo      <= tmo_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cnt_nxt       = cnt;
    load_buf_nxt  = load_buf;
    tmo_nxt       = tmo;
    dmem.dmem_req = 1'b0;
    mem_stall     = 1'b0;
    fault         = 1'b0;
    fault_cause   = FC_NONE;
    out           = '0;
    if (in.valid_ex_mem) begin
      out.alu_result   = in.alu_result;
      out.rd_addr      = in.rd_addr;
      out.ctrl         = in.ctrl;
      out.valid_mem_wb = 1'b1;
    end

    case (state)
      IDLE: begin
        if (is_mem && misaligned) begin
          out.ctrl.reg_write = 1'b0;
          fault              = 1'b1;
          fault_cause        = in.ctrl.mem_write ? FC_MISALIGN_ST : FC_MISALIGN_LD;
        end else if (is_mem) begin
          dmem.dmem_req = 1'b1;
          // A granted store retires now; everything else holds the pipe.
          if (!(in.ctrl.mem_write && dmem.dmem_gnt)) begin
            mem_stall        = 1'b1;
            out.valid_mem_wb = 1'b0;
          end
          if (!in.ctrl.mem_write && dmem.dmem_gnt) begin
            state_nxt    = WAIT_RSP;
            cnt_nxt      = '0;
            tmo_nxt      = 1'b0;
            load_buf_nxt = '0;
          end
        end
      end

      WAIT_RSP: begin
        mem_stall        = 1'b1;
        out.valid_mem_wb = 1'b0;
        cnt_nxt          = cnt + 1'b1;
        if (dmem.dmem_rvalid) begin
          load_buf_nxt = dmem.dmem_rdata;
          state_nxt    = RSP_DONE;
        end else if (cnt == CNT_LAST) begin
          tmo_nxt   = 1'b1;
          state_nxt = RSP_DONE;
        end
      end

      RSP_DONE: begin
        out.mem_rdata = ld_data;
        state_nxt     = IDLE;
        if (tmo) begin
          out.ctrl.reg_write = 1'b0;
          fault              = 1'b1;
          fault_cause        = FC_TIMEOUT;
        end
      end

      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, extension, misalignment,
// bus timeout and reset during an outstanding access.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  ex_mem_reg_t in;
  mem_wb_reg_t out;
  logic        mem_stall;
  logic        fault;
  logic [1:0]  fault_cause;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          stalls;

  mem_stage_if bus ();

  mem_stage #(.XLEN(32), .TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .dmem        (bus.master),
    .mem_stall   (mem_stall),
    .out         (out),
    .fault       (fault),
    .fault_cause (fault_cause)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ex_mem_reg_t mk(input logic [31:0] addr, input logic [31:0] rs2,
                                     input logic rd, input logic wr,
                                     input logic [1:0] sz, input logic uns);
    ex_mem_reg_t o;
    o                   = '0;
    o.alu_result        = addr;
    o.rs2_data_str      = rs2;
    o.rd_addr           = 5'd7;
    o.ctrl.mem_read     = rd;
    o.ctrl.mem_write    = wr;
    o.ctrl.mem_size     = sz;
    o.ctrl.mem_unsigned = uns;
    o.ctrl.reg_write    = !wr;
    o.ctrl.wb_sel       = 2'd1;
    o.valid_ex_mem      = 1'b1;
    return o;
  endfunction

  task automatic bubble();
    @(negedge clk);
    in              = '0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    #1;
  endtask

  // Grant on the first cycle, rvalid at cycle rsp_at (negative: never).
  // Returns in the first non-stalled cycle, before its clock edge.
  task automatic run_load(input ex_mem_reg_t o, input int rsp_at,
                          input logic [31:0] rdata, output int n_stall);
    n_stall = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      in              = o;
      bus.dmem_gnt    = (i == 0);
      bus.dmem_rvalid = (i == rsp_at);
      bus.dmem_rdata  = (i == rsp_at) ? rdata : 32'h0;
      #1;
      if (i == 0) chk("ld_req_issue", {31'b0, bus.dmem_req}, 32'd1);
      if (i == 1) chk("ld_req_wait", {31'b0, bus.dmem_req}, 32'd0);
      if (!mem_stall) return;
      n_stall++;
    end
    chk("ld_bound", {31'b0, mem_stall}, 32'd0);
  endtask

  initial begin
    reset           = 1'b1;
    in              = '0;
    bus.dmem_gnt    = 1'b0;
    bus.dmem_rvalid = 1'b0;
    bus.dmem_rdata  = 32'h0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req",   {31'b0, bus.dmem_req}, 32'd0);
    chk("rst_stall", {31'b0, mem_stall}, 32'd0);
    chk("rst_fault", {31'b0, fault}, 32'd0);
    chk("rst_out0",  {31'b0, (out == '0)}, 32'd1);

    // ALU op passes straight through
    @(negedge clk);
    in = mk(32'h55, 32'h0, 1'b0, 1'b0, SZ_W, 1'b0);
    #1;
    chk("alu_res",   out.alu_result, 32'h55);
    chk("alu_vld",   {31'b0, out.valid_mem_wb}, 32'd1);
    chk("alu_rdata", out.mem_rdata, 32'h0);
    chk("alu_stall", {31'b0, mem_stall}, 32'd0);
    chk("alu_req",   {31'b0, bus.dmem_req}, 32'd0);

    // LW 0x100, response three cycles after grant
    run_load(mk(32'h100, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0), 3, 32'hDEADBEEF, stalls);
    chk("lw_stalls", stalls, 32'd4);
    chk("lw_rdata",  out.mem_rdata, 32'hDEADBEEF);
    chk("lw_vld",    {31'b0, out.valid_mem_wb}, 32'd1);
    chk("lw_regwr",  {31'b0, out.ctrl.reg_write}, 32'd1);
    bubble();

    run_load(mk(32'h103, 32'h0, 1'b1, 1'b0, SZ_B, 1'b0), 1, 32'h80FFFFFF, stalls);
    chk("lb_rdata", out.mem_rdata, 32'hFFFFFF80);
    bubble();
    run_load(mk(32'h103, 32'h0, 1'b1, 1'b0, SZ_B, 1'b1), 1, 32'h80FFFFFF, stalls);
    chk("lbu_rdata", out.mem_rdata, 32'h00000080);
    bubble();
    run_load(mk(32'h102, 32'h0, 1'b1, 1'b0, SZ_H, 1'b0), 2, 32'h80FFFFFF, stalls);
    chk("lh_rdata", out.mem_rdata, 32'hFFFF80FF);
    bubble();
    run_load(mk(32'h100, 32'h0, 1'b1, 1'b0, SZ_H, 1'b1), 1, 32'h1234F00D, stalls);
    chk("lhu_rdata", out.mem_rdata, 32'h0000F00D);
    bubble();

    // SH 0x202, grant arrives on the third cycle
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in           = mk(32'h202, 32'h1234ABCD, 1'b0, 1'b1, SZ_H, 1'b0);
      bus.dmem_gnt = (i == 2);
      #1;
      chk("sh_req",   {31'b0, bus.dmem_req}, 32'd1);
      chk("sh_we",    {31'b0, bus.dmem_we}, 32'd1);
      chk("sh_addr",  bus.dmem_addr, 32'h200);
      chk("sh_be",    {28'b0, bus.dmem_be}, 32'hC);
      chk("sh_wdata", bus.dmem_wdata, 32'hABCDABCD);
      chk("sh_stall", {31'b0, mem_stall}, (i == 2) ? 32'd0 : 32'd1);
      chk("sh_vld",   {31'b0, out.valid_mem_wb}, (i == 2) ? 32'd1 : 32'd0);
    end
    bubble();
    chk("sh_done_req", {31'b0, bus.dmem_req}, 32'd0);

    @(negedge clk);
    in           = mk(32'h201, 32'h000000CD, 1'b0, 1'b1, SZ_B, 1'b0);
    bus.dmem_gnt = 1'b1;
    #1;
    chk("sb_be",    {28'b0, bus.dmem_be}, 32'h2);
    chk("sb_wdata", bus.dmem_wdata, 32'hCDCDCDCD);
    chk("sb_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    in = mk(32'h300, 32'hCAFEF00D, 1'b0, 1'b1, SZ_W, 1'b0);
    #1;
    chk("sw_be",    {28'b0, bus.dmem_be}, 32'hF);
    chk("sw_wdata", bus.dmem_wdata, 32'hCAFEF00D);
    bubble();

    // Misaligned load and store
    @(negedge clk);
    in = mk(32'h101, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
    #1;
    chk("mis_ld_req",   {31'b0, bus.dmem_req}, 32'd0);
    chk("mis_ld_fault", {31'b0, fault}, 32'd1);
    chk("mis_ld_cause", {30'b0, fault_cause}, 32'd1);
    chk("mis_ld_regwr", {31'b0, out.ctrl.reg_write}, 32'd0);
    chk("mis_ld_vld",   {31'b0, out.valid_mem_wb}, 32'd1);
    chk("mis_ld_stall", {31'b0, mem_stall}, 32'd0);
    @(negedge clk);
    in = mk(32'h203, 32'h0, 1'b0, 1'b1, SZ_H, 1'b0);
    #1;
    chk("mis_st_req",   {31'b0, bus.dmem_req}, 32'd0);
    chk("mis_st_cause", {30'b0, fault_cause}, 32'd2);
    bubble();
    chk("fault_clear", {31'b0, fault}, 32'd0);

    // Granted load, no response: timeout after 8 cycles in WAIT_RSP
    run_load(mk(32'h104, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0), -1, 32'h0, stalls);
    chk("tmo_stalls", stalls, 32'd9);
    chk("tmo_fault",  {31'b0, fault}, 32'd1);
    chk("tmo_cause",  {30'b0, fault_cause}, 32'd3);
    chk("tmo_regwr",  {31'b0, out.ctrl.reg_write}, 32'd0);
    chk("tmo_vld",    {31'b0, out.valid_mem_wb}, 32'd1);
    bubble();
    chk("tmo_pulse", {31'b0, fault}, 32'd0);

    // Reset while the load is outstanding; late response must be dropped
    @(negedge clk);
    in           = mk(32'h108, 32'h0, 1'b1, 1'b0, SZ_W, 1'b0);
    bus.dmem_gnt = 1'b1;
    @(negedge clk);
    bus.dmem_gnt = 1'b0;
    #1;
    chk("rstw_stall_pre", {31'b0, mem_stall}, 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset           = 1'b0;
    in              = '0;
    bus.dmem_rvalid = 1'b1;
    bus.dmem_rdata  = 32'h11111111;
    #1;
    chk("rstw_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstw_req",   {31'b0, bus.dmem_req}, 32'd0);
    chk("rstw_out0",  {31'b0, (out == '0)}, 32'd1);
    bubble();
    chk("rstw_late_stall", {31'b0, mem_stall}, 32'd0);
    chk("rstw_late_fault", {31'b0, fault}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
